// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO for the five-stage MIPS pipeline.
// Launches mult/div from E, counts a fixed latency, commits to HI/LO and stalls D-stage HI/LO users.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpD,
  input  logic [5:0]  FunctD,
  input  logic [5:0]  OpE,
  input  logic [5:0]  FunctE,
  input  logic        ValidE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Start,
  output logic        Busy,
  output logic        StallMD,
  output logic        state_dbg
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    pend_kind;
  logic [31:0]   pend_a, pend_b;
  logic          commit;

  logic e_special, e_md, e_mthi, e_mtlo, d_hilo;

  assign e_special = (OpE == 6'd0);
  assign e_md      = e_special && (FunctE[5:2] == 4'b0110);
  assign e_mthi    = e_special && (FunctE == 6'b010001);
  assign e_mtlo    = e_special && (FunctE == 6'b010011);
  assign d_hilo    = (OpD == 6'd0) && ((FunctD[5:2] == 4'b0110) || (FunctD[5:2] == 4'b0100));

  assign Start   = ValidE && e_md && !Busy;
  assign StallMD = d_hilo && (Start || Busy);

  // Handshake: Start is a one-cycle launch pulse; Busy covers exactly the N latency cycles
  // after it, and results land in HI/LO at the edge ending the last Busy cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = RUN;
      RUN:  if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state == RUN);
    commit    = (state == RUN) && (cnt == CW'(1));
    state_dbg = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      pend_kind <= 2'b00;
      pend_a    <= '0;
      pend_b    <= '0;
    end else if (Start) begin
      cnt       <= FunctE[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend_kind <= FunctE[1:0];
      pend_a    <= A;
      pend_b    <= B;
    end else if (Busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  // funct[0]=0 selects the signed flavour; funct[1]=1 selects divide.
  logic        signed_op, a_neg, b_neg;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, den, q_mag, r_mag, quot, rem;

  always_comb begin
    signed_op = !pend_kind[0];
    ext_a = signed_op ? {{32{pend_a[31]}}, pend_a} : {32'd0, pend_a};
    ext_b = signed_op ? {{32{pend_b[31]}}, pend_b} : {32'd0, pend_b};
    prod  = ext_a * ext_b;
    // Divide on magnitudes so 0x80000000 / -1 falls out without overflow handling.
    a_neg = signed_op && pend_a[31];
    b_neg = signed_op && pend_b[31];
    mag_a = a_neg ? -pend_a : pend_a;
    mag_b = b_neg ? -pend_b : pend_b;
    den   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / den;
    r_mag = mag_a % den;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (!pend_kind[1]) begin
        HI <= prod[63:32];
        LO <= prod[31:0];
      end else if (pend_b != 32'd0) begin
        HI <= rem;
        LO <= quot;
      end
    end else if (ValidE && !Busy) begin
      if (e_mthi) HI <= A;
      if (e_mtlo) LO <= A;
    end
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline. It owns the HI/LO registers. It launches mult/multu/div/divu from the E stage and counts out a fixed latency before committing results. It raises a decode-stage stall while any later HI/LO instruction would observe or disturb an operation in flight. It sits beside the ALU in E, and its stall output is ORed into the hazard logic alongside the decode-stage PC controller.

## Interface

- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (>=1)

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- OpD  in  6  D-stage opcode
- FunctD  in  6  D-stage funct
- OpE  in  6  E-stage opcode
- FunctE  in  6  E-stage funct
- ValidE  in  1  E-stage holds a real instruction, not a bubble
- A  in  32  E-stage rs operand
- B  in  32  E-stage rt operand
- HI  out  32  HI register
- LO  out  32  LO register
- Start  out  1  combinational: a mult/div is launching this cycle
- Busy  out  1  registered: operation in flight
- StallMD  out  1  combinational: hold the D stage

## Operation

- Decode uses Op == 6'b000000 (special) with these funct codes:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
- Start = ValidE & E-stage is mult/multu/div/divu & ~Busy.
- StallMD = D-stage is any of the eight funct codes above & (Start | Busy).
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, down-counter cnt active.
- IDLE -> RUN on Start.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Latch op kind, A and B into pending registers.
- RUN: cnt decrements each cycle.
  - When cnt==1, the next edge commits results to HI/LO and returns to IDLE.
- mult: {HI,LO} = $signed(A)*$signed(B), full 64-bit product.
- multu: {HI,LO} = A*B, both operands unsigned.
- div: LO = signed quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
- div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B and HI = A%B, unsigned.
- Divide by zero (B==0):
  - Full DIV_CYCLES latency is still consumed.
  - HI and LO are left unchanged at commit.
- mthi/mtlo with ValidE and ~Busy: write A to HI/LO at the end of the cycle.
- mthi/mtlo arriving while Busy: ignored. Stall logic prevents this, and the bench checks that it never happens.
- mult/div in E while Busy: ignored, Start stays 0. This is unreachable under correct stalling.
- mfhi/mflo: the datapath reads HI/LO directly. This block does no forwarding.
- Any count of pending-register width is acceptable. The counter width is clog2(max(MULT_CYCLES,DIV_CYCLES))+1.

## Timing

- Reset (synchronous): HI=0, LO=0, Busy=0, state IDLE, cnt=0.
  - Reset mid-operation aborts the operation and commits no result.
- Start is high in cycle T.
- Busy is high in cycles T+1 through T+N, where N is the op's latency.
- HI/LO take their new values at the edge ending cycle T+N. Busy=0 in T+N+1.
- An mfhi held in D by StallMD in T..T+N leaves D in T+N+1. It reads the committed HI in E at T+N+2.
- Back-to-back mult then mult: the second is stalled in D until T+N+1. It reaches E and launches at T+N+2.
- mthi in E at cycle T: HI updates at the edge ending T. Its value is visible in T+1.
- ValidE=0: no Start and no mthi/mtlo effect, whatever OpE/FunctE hold.

## Test plan

- Reset, then mult with A=0xFFFFFFFF, B=2:
  - Start=1 for 1 cycle, Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2:
  - After 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div with A=-7 (0xFFFFFFF9), B=2:
  - Busy=1 for 10 cycles.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- div by zero:
  - Preload HI=0x11111111, LO=0x22222222 with mthi/mtlo.
  - Run divu with A=5, B=0.
  - Busy is high for 10 cycles. HI and LO are unchanged afterwards.
- Hazard sequence mult, then mflo in D the following cycle:
  - StallMD=1 from the Start cycle through the last Busy cycle (6 cycles), then drops.
  - An add in D alongside Busy gives StallMD=0.
- Reset asserted on the 3rd Busy cycle of a div:
  - Next cycle Busy=0, HI=0, LO=0.
  - No commit occurs afterwards.
  - A subsequent mult completes normally.
